// File: rtl/toggle_port_scheduler_pkg.sv
// Shared types and helpers for the toggle port scheduler.
package cva5_types;

  localparam int DEFAULT_DEPTH       = 8;
  localparam int DEFAULT_NUM_SOURCES = 3;
  localparam int DEFAULT_FIFO_DEPTH  = 2;

  localparam int ID_W = $clog2(DEFAULT_DEPTH);
  localparam int RR_W = $clog2(DEFAULT_NUM_SOURCES);

  typedef logic [ID_W-1:0] toggle_id_t;

  // Round-robin successor of a granted source index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/toggle_req_fifo.sv
// Small flop-based FIFO buffering one requester's toggle IDs in arrival order.
module toggle_req_fifo
  import cva5_types::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ID_W       = $clog2(DEFAULT_DEPTH),
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [ID_W-1:0]  data_in,
  output logic [ID_W-1:0]  data_out,
  output logic [CNT_W-1:0] count
);

  logic [ID_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage carries no reset; the head is only observed when count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= data_in;
  end

  assign data_out = mem[rd_ptr];

endmodule

// File: rtl/toggle_port_scheduler.sv
// Funnels toggle requests from several completion units onto the single
// toggle port of the toggle-bit memory, one request per cycle, round-robin.
module toggle_port_scheduler
  import cva5_types::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  localparam int IDW        = $clog2(DEPTH),
  localparam int SRC_W      = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SOURCES-1:0]          src_valid,
  input  logic [NUM_SOURCES-1:0][IDW-1:0] src_id,
  output logic [NUM_SOURCES-1:0]          src_ready,
  input  logic                            flush,
  output logic                            toggle,
  output logic [IDW-1:0]                  toggle_id,
  output logic                            idle
);

  logic [IDW-1:0]         heads  [NUM_SOURCES];
  logic [CNT_W-1:0]       counts [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] nonempty;
  logic [NUM_SOURCES-1:0] push;
  logic [NUM_SOURCES-1:0] pop;
  logic [SRC_W-1:0]       rr_ptr;
  logic [SRC_W-1:0]       grant_idx;
  logic                   grant_vld;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    // Ready depends only on the registered count, so a full FIFO stays
    // not-ready even in the cycle it is popped.
    assign src_ready[i] = (counts[i] != CNT_W'(FIFO_DEPTH)) & ~flush;
    assign push[i]      = src_valid[i] & src_ready[i];
    assign pop[i]       = toggle && (grant_idx == SRC_W'(i));
    assign nonempty[i]  = (counts[i] != '0);

    toggle_req_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ID_W       (IDW)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (push[i]),
      .pop      (pop[i]),
      .data_in  (src_id[i]),
      .data_out (heads[i]),
      .count    (counts[i])
    );
  end

  // Round-robin search over non-empty FIFOs starting at rr_ptr, wrapping.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SOURCES;
      if (!grant_vld && nonempty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'(idx);
      end
    end
  end

  // Drive the memory port; flush suppresses the strobe for its cycle.
  always_comb begin
    toggle    = grant_vld & ~flush;
    toggle_id = toggle ? heads[grant_idx] : '0;
  end

  // Idle reflects registered occupancy of every FIFO.
  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (nonempty[i]) idle = 1'b0;
    end
  end

  // Priority pointer moves just past the source that was served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (toggle) begin
      rr_ptr <= SRC_W'(rr_next(int'(grant_idx), NUM_SOURCES));
    end
  end

endmodule

// File: doc/toggle_port_scheduler.md
# toggle_port_scheduler

Shares the single toggle port of a toggle-bit memory between NUM_SOURCES independent requesters, such as writeback, branch-resolve and exception units that each mark IDs done. Each source pushes ID-toggle requests through a valid/ready handshake into a small private FIFO. A round-robin arbiter drains at most one request per cycle onto the memory's `toggle`/`toggle_id` inputs. The block sits between the completion units and the toggle memory; the memory itself stays outside.

## Interface
Parameters:
- DEPTH, 8: number of IDs in the toggle memory; ID width is $clog2(DEPTH).
- NUM_SOURCES, 3: number of requesters, 2 or more.
- FIFO_DEPTH, 2: per-source buffer entries, a power of two, 2 or more.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- src_valid  in  [NUM_SOURCES]  source i presents a toggle request.
- src_id  in  [NUM_SOURCES] x $clog2(DEPTH)  ID to toggle for source i.
- src_ready  out  [NUM_SOURCES]  source i's FIFO can accept; a request is accepted when valid & ready.
- flush  in  1  discards every buffered request.
- toggle  out  1  drives the toggle memory's toggle strobe.
- toggle_id  out  $clog2(DEPTH)  drives the toggle memory's toggle_id.
- idle  out  1  all FIFOs are empty.

## Operation
- Per-source FIFO holds accepted IDs in order. It has a write pointer, a read pointer and a count of width $clog2(FIFO_DEPTH)+1.
- src_ready[i] = (count_i != FIFO_DEPTH) & ~flush.
  - Derived from registered count only; there is no combinational path from a same-cycle pop.
  - A full FIFO therefore stays not-ready in its pop cycle.
- Arbiter: combinational round-robin over the non-empty FIFOs.
  - Search starts at rr_ptr and wraps modulo NUM_SOURCES.
  - On a grant, rr_ptr becomes (granted+1) mod NUM_SOURCES.
  - With no grant, rr_ptr holds.
- toggle = any FIFO non-empty & ~flush.
- toggle_id = head entry of the granted FIFO; 0 when toggle=0.
- The granted FIFO pops on the same edge.
- Same source, push and pop in the same cycle: count is unchanged and both pointers advance.
- No merging of duplicate IDs. Two queued toggles on the same ID are both issued and cancel in memory; ordering this correctly is the requesters' responsibility.
- flush:
  - Counts and pointers go to 0 and rr_ptr goes to 0.
  - Same-cycle pushes are rejected, since ready=0.
  - No toggle is issued in the flush cycle.
- idle = all counts zero, taken from registers.

## Timing
- Reset values:
  - All FIFOs empty, rr_ptr=0.
  - toggle=0, toggle_id=0, idle=1, src_ready=all 1.
- Latency: a request accepted in cycle N is visible at the earliest as toggle=1 in cycle N+1, when its FIFO was empty and it wins arbitration.
- Throughput: one toggle per cycle overall. Under contention, each of k busy sources is served at least once every k cycles.
- Reset asserted mid-operation clears all state immediately; queued requests are lost. Outputs reach their reset values without waiting for a clock edge.
- Reset deassertion is assumed synchronized externally; the first active edge follows release.

## Structure
- Shared package (cva5_types):
  - typedef toggle_id_t = logic [$clog2(DEPTH)-1:0];
  - localparam for the rr_ptr width, $clog2(NUM_SOURCES).
- Sub-module `toggle_req_fifo`, instantiated NUM_SOURCES times:
  - ports clk, rst, push, pop, data_in, data_out, count;
  - a flush input clears it;
  - flop-based storage, FIFO_DEPTH entries.
- Arbiter, rr_ptr and output muxing stay in the top module.

## Test plan
- Single request: source 1 pushes ID 5 in cycle 0 → toggle=1, toggle_id=5 in cycle 1; idle=1 in cycle 2.
- Contention: all 3 sources push IDs 1, 2, 3 in cycle 0 → toggle_ids 1, 2, 3 in cycles 1-3. After two more push rounds, grant order rotates 0→1→2 with no source starved.
- Backpressure: source 0 pushes every cycle while source 2 holds priority.
  - Expect src_ready[0]=0 after 2 outstanding entries.
  - No request is lost; all IDs emerge in push order.
- Flush: queue 4 requests, then assert flush for one cycle.
  - Flush cycle: toggle=0 and src_ready=0.
  - Next cycle: idle=1 and rr_ptr=0.
  - A later push of ID 7 emerges alone.
- Async reset mid-burst: drop rst between edges with 3 entries queued → toggle=0, idle=1 and src_ready=all 1 before the next edge.
- Duplicate ID: source 0 pushes ID 4 twice → two toggles with id 4 on consecutive cycles; a model toggle memory reads 0 afterwards.
